jp_inv_process: RTL and testbench
=================================

Name: jp_inv_process

Overview:
- Inverse 5/3 lifting engine; the decoder-side counterpart of the forward lifting step.
- Accepts one packed job of 16 lanes: left/sample/right 9-bit signed samples plus 5-bit per-lane flags.
- Reconstructs each lane serially, one per cycle, and writes 10-bit results into the result RAM through a ready/we write port.
- Sits between the packed-sample RAMs/flags ROM readout and ram_res.

Parameters:
- LANES, 16, lanes per packed word.
- W_SAMP, 9, signed sample width per lane.
- W_FLG, 5, flag bits per lane.
- W_RES, 10, signed result width.
- W_ADDR, 10, result RAM address width.

Ports:
- clk_fast  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- left_s_i  in  144  packed left neighbours; lane i = bits [9i+8:9i].
- sam_s_i  in  144  packed centre samples; same lane packing.
- right_s_i  in  144  packed right neighbours; same lane packing.
- flgs_s_i  in  80  packed flags; lane i = bits [5i+4:5i].
- base_addr  in  10  result RAM address of lane 0.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at job end.
- res_we  out  1  write request to result RAM.
- res_addr  out  10  write address.
- res_din  out  10  signed result.
- res_ready  in  1  RAM accepts the write this cycle.

Behaviour:
- Reset values: busy=0, done=0, res_we=0, res_addr=0, res_din=0; FSM=IDLE; lane counter=0.
- Flag bits per lane:
  - [0] odd: 1 = inverse predict, 0 = inverse update.
  - [1] left edge: use right in place of left.
  - [2] right edge: use left in place of right.
  - [3] lane enable.
  - [4] reserved; ignored.
- If both edge bits are set: L = R = sam.
- Arithmetic: sign-extend all samples to 12 bits.
  - Odd lane: x = sam + ((L+R) >>> 1).
  - Even lane: x = sam - ((L+R+2) >>> 2).
  - Shifts are arithmetic.
  - Result range is always within 10-bit signed [-384..383 even, -512..510 odd]; take the low 10 bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures all packed inputs and base_addr into internal registers, clears the lane counter, and goes to RUN.
  - Later input changes have no effect on the current job.
- RUN, per lane k:
  - Enabled lane: res_we=1, res_addr=base_addr+k (mod 1024, wraps), res_din=x(k), all registered.
  - Advance to k+1 only on a cycle with res_we && res_ready. While res_ready=0, hold we/addr/din stable.
  - Disabled lane: res_we=0 for one cycle, then advance.
  - After lane 15 completes, go to DONE.
- Latency: with res_ready held high, the first write is visible the cycle after start. Lanes occupy cycles 1..16, done pulses in cycle 17, and IDLE is entered in cycle 18.
- DONE: done=1 and busy=0 for one cycle; then IDLE.
- start while busy or in DONE: ignored; no queueing.
- start in IDLE together with rst: rst wins.
- rst mid-job: return to IDLE immediately. No further writes, no done pulse; the partial job is lost.

Optional Feature:
- Macro: JP_WCNT_EN.
- Defined:
  - Adds output wr_count [4:0], the number of lanes actually written in the last job (0..16).
  - Updated in the DONE cycle and held until the next DONE.
  - Reset value is 0.
- Undefined: port absent; no counter logic.

Decomposition:
- Package jp_pkg holds:
  - width constants LANES, W_SAMP, W_FLG, W_RES, W_ADDR;
  - flag bit indices FLG_ODD=0, FLG_LEDGE=1, FLG_REDGE=2, FLG_EN=3;
  - the FSM state enum.
- One combinational sub-module, jp_inv_lane: takes 9-bit L/S/R plus 5-bit flags and returns the 10-bit result.
- jp_inv_process instantiates jp_inv_lane once on the lane-mux output.

Test Plan:
- Lane0 L=160, S=164, R=156, flags=5'b01001 (odd, enabled); other lanes disabled; res_ready=1 -> one write: addr=base_addr, din=322; done pulses 17 cycles after start.
- Same samples, flags=5'b01000 (even) -> din=85.
- Odd lane with left edge (5'b01011) -> din=320 (L replaced by 156). With both edges set -> din=164+164=328.
- All 16 lanes enabled, base_addr=1020, res_ready=1 -> 16 writes at 1020..1023, then 0..11; busy is high for 16 cycles.
- res_ready low for 3 cycles during lane 5 -> lane 5 write held stable for 4 cycles, then continues; done is delayed by 3 cycles.
- rst asserted at lane 8 -> outputs return to reset values next cycle, no done pulse; a new start then runs a clean job. With JP_WCNT_EN, a job with 7 enabled lanes -> wr_count=7.

Source files
------------

// File: rtl/jp_pkg.sv
// jp_pkg: shared widths, flag bit positions and FSM states for the inverse 5/3 lifting engine
package jp_pkg;
    localparam int LANES     = 16;
    localparam int W_SAMP    = 9;
    localparam int W_FLG     = 5;
    localparam int W_RES     = 10;
    localparam int W_ADDR    = 10;
    localparam int W_LANE    = $clog2(LANES);
    localparam int W_CNT     = $clog2(LANES) + 1;
    localparam int FLG_ODD   = 0;
    localparam int FLG_LEDGE = 1;
    localparam int FLG_REDGE = 2;
    localparam int FLG_EN    = 3;
    localparam int FLG_RSV   = 4;
    localparam logic [W_LANE-1:0] LAST_LANE = W_LANE'(LANES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/jp_inv_process_if.sv
// jp_inv_process_if: job request (packed samples, flags, base address) and result-RAM write port
interface jp_inv_process_if;
    import jp_pkg::*;
    logic                      start;
    logic [LANES*W_SAMP-1:0]   left_s_i;
    logic [LANES*W_SAMP-1:0]   sam_s_i;
    logic [LANES*W_SAMP-1:0]   right_s_i;
    logic [LANES*W_FLG-1:0]    flgs_s_i;
    logic [W_ADDR-1:0]         base_addr;
    logic                      busy;
    logic                      done;
    logic                      res_we;
    logic [W_ADDR-1:0]         res_addr;
    logic [W_RES-1:0]          res_din;
    logic                      res_ready;
    modport master (
        output start, left_s_i, sam_s_i, right_s_i, flgs_s_i, base_addr, res_ready,
        input  busy, done, res_we, res_addr, res_din
    );
    modport slave (
        input  start, left_s_i, sam_s_i, right_s_i, flgs_s_i, base_addr, res_ready,
        output busy, done, res_we, res_addr, res_din
    );
endinterface

// File: rtl/jp_inv_lane.sv
// jp_inv_lane: combinational inverse 5/3 step for one lane (predict on odd lanes, update on even)
module jp_inv_lane
    import jp_pkg::*;
(
    input  logic [W_SAMP-1:0] i_l,
    input  logic [W_SAMP-1:0] i_s,
    input  logic [W_SAMP-1:0] i_r,
    input  logic [W_FLG-1:0]  i_flg,
    output logic [W_RES-1:0]  o_res
);
    logic signed [11:0] w_l, w_s, w_r, w_le, w_re, w_sum, w_x;
    logic               w_both;
    logic               w_unused;
    // Edge substitution, then odd: s + (L+R)/2, even: s - (L+R+2)/4, all in 12-bit signed
    always_comb begin
        w_l    = {{(12-W_SAMP){i_l[W_SAMP-1]}}, i_l};
        w_s    = {{(12-W_SAMP){i_s[W_SAMP-1]}}, i_s};
        w_r    = {{(12-W_SAMP){i_r[W_SAMP-1]}}, i_r};
        w_both = i_flg[FLG_LEDGE] && i_flg[FLG_REDGE];
        w_le   = w_both ? w_s : i_flg[FLG_LEDGE] ? w_r : w_l;
        w_re   = w_both ? w_s : i_flg[FLG_REDGE] ? w_l : w_r;
        w_sum  = w_le + w_re;
        w_x    = i_flg[FLG_ODD] ? w_s + (w_sum >>> 1) : w_s - ((w_sum + 12'sd2) >>> 2);
        o_res  = w_x[W_RES-1:0];
    end
    // The reserved flag and the sign-extension bits above the result never influence the output
    assign w_unused = ^{i_flg[FLG_RSV], w_x[11:W_RES]};
endmodule

// File: rtl/jp_inv_process.sv
// jp_inv_process: serial 16-lane inverse 5/3 lifting engine writing results to the result RAM
// Optional macro JP_WCNT_EN adds wr_count, the number of lanes written in the last job.
module jp_inv_process
    import jp_pkg::*;
(
    input  logic               clk_fast,
    input  logic               rst,
`ifdef JP_WCNT_EN
    output logic [W_CNT-1:0]   wr_count,
`endif
    jp_inv_process_if.slave    bus
);
    state_t                    r_state;
    logic [W_LANE-1:0]         r_k;
    logic [LANES*W_SAMP-1:0]   r_left, r_sam, r_right;
    logic [LANES*W_FLG-1:0]    r_flg;
    logic [W_ADDR-1:0]         r_base, r_addr;
    logic [W_RES-1:0]          r_din;
    logic                      r_busy, r_done, r_we;
    logic                      w_idle, w_adv;
    logic [W_LANE-1:0]         w_nk;
    logic [LANES*W_SAMP-1:0]   w_left, w_sam, w_right;
    logic [LANES*W_FLG-1:0]    w_flgs;
    logic [W_ADDR-1:0]         w_base, w_addr;
    logic [W_SAMP-1:0]         w_l, w_s, w_r;
    logic [W_FLG-1:0]          w_f;
    logic [W_RES-1:0]          w_res;
`ifdef JP_WCNT_EN
    logic [W_CNT-1:0]          r_acc, r_wcnt, w_acc;
`endif

    // Lane to load next: lane 0 of the incoming job while idle, otherwise the lane after r_k
    always_comb begin
        w_idle  = r_state == IDLE;
        w_nk    = w_idle ? '0 : r_k + W_LANE'(1);
        w_left  = w_idle ? bus.left_s_i  : r_left;
        w_sam   = w_idle ? bus.sam_s_i   : r_sam;
        w_right = w_idle ? bus.right_s_i : r_right;
        w_flgs  = w_idle ? bus.flgs_s_i  : r_flg;
        w_base  = w_idle ? bus.base_addr : r_base;
        w_l     = w_left[int'(w_nk)*W_SAMP +: W_SAMP];
        w_s     = w_sam[int'(w_nk)*W_SAMP +: W_SAMP];
        w_r     = w_right[int'(w_nk)*W_SAMP +: W_SAMP];
        w_f     = w_flgs[int'(w_nk)*W_FLG +: W_FLG];
        w_addr  = w_base + W_ADDR'(w_nk);
        w_adv   = !r_we || bus.res_ready;
    end

    jp_inv_lane u_lane (
        .i_l   (w_l),
        .i_s   (w_s),
        .i_r   (w_r),
        .i_flg (w_f),
        .o_res (w_res)
    );

`ifdef JP_WCNT_EN
    assign w_acc    = r_acc + W_CNT'(r_we && bus.res_ready);
    assign wr_count = r_wcnt;
`endif

    // Job FSM: capture on start, present one lane at a time, hold a write until the RAM accepts it
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_left  <= '0;
            r_sam   <= '0;
            r_right <= '0;
            r_flg   <= '0;
            r_base  <= '0;
`ifdef JP_WCNT_EN
            r_acc   <= '0;
            r_wcnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_left  <= bus.left_s_i;
                    r_sam   <= bus.sam_s_i;
                    r_right <= bus.right_s_i;
                    r_flg   <= bus.flgs_s_i;
                    r_base  <= bus.base_addr;
                    r_k     <= '0;
                    r_busy  <= 1'b1;
                    r_we    <= w_f[FLG_EN];
                    r_addr  <= w_addr;
                    r_din   <= w_res;
                    r_state <= RUN;
`ifdef JP_WCNT_EN
                    r_acc   <= '0;
`endif
                end
                RUN: if (w_adv) begin
`ifdef JP_WCNT_EN
                    r_acc <= w_acc;
`endif
                    if (r_k == LAST_LANE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= DONE;
`ifdef JP_WCNT_EN
                        r_wcnt  <= w_acc;
`endif
                    end else begin
                        r_k    <= w_nk;
                        r_we   <= w_f[FLG_EN];
                        r_addr <= w_addr;
                        r_din  <= w_res;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.res_we   = r_we;
    assign bus.res_addr = r_addr;
    assign bus.res_din  = r_din;
endmodule

// File: tb/tb_jp_inv_process.sv
// tb_jp_inv_process: directed self-checking bench for the inverse 5/3 lifting engine
module tb_jp_inv_process;
    import jp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    jp_inv_process_if bus ();
`ifdef JP_WCNT_EN
    logic [W_CNT-1:0] wr_count;
`endif

    jp_inv_process dut (
        .clk_fast (clk),
        .rst      (rst),
`ifdef JP_WCNT_EN
        .wr_count (wr_count),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr, done_cyc, busy_cyc, first_wr, hold5, hold_chg, n_done, n_w;
    logic [W_ADDR-1:0] wa [64];
    logic [W_RES-1:0]  wd [64];
    logic [W_RES-1:0]  d5;
    logic [W_ADDR-1:0] exp_a [5] = '{10'd200, 10'd201, 10'd202, 10'd203, 10'd205};
    logic [W_RES-1:0]  exp_d [5] = '{10'd1014, 10'd894, 10'd510, 10'd640, 10'd30};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        bus.left_s_i  = '0;
        bus.sam_s_i   = '0;
        bus.right_s_i = '0;
        bus.flgs_s_i  = '0;
    endtask

    task automatic set_lane(input int k, input int l, input int s, input int r, input logic [4:0] f);
        bus.left_s_i[k*W_SAMP +: W_SAMP]  = 9'(l);
        bus.sam_s_i[k*W_SAMP +: W_SAMP]   = 9'(s);
        bus.right_s_i[k*W_SAMP +: W_SAMP] = 9'(r);
        bus.flgs_s_i[k*W_FLG +: W_FLG]    = f;
    endtask

    // Launch a job and log every accepted write; res_ready drops for stall_n cycles from stall_at
    task automatic run_job(input logic [W_ADDR-1:0] base, input int stall_at, input int stall_n);
        n_wr = 0; done_cyc = -1; busy_cyc = 0; first_wr = -1; hold5 = 0; hold_chg = 0;
        bus.base_addr = base;
        bus.start     = 1'b1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            tick();
            bus.start     = (c == 5);
            bus.res_ready = !(c >= stall_at && c < stall_at + stall_n);
            if (bus.busy) busy_cyc++;
            if (bus.done) done_cyc = c;
            if (bus.res_we && bus.res_addr == base + 10'd5) begin
                if (hold5 == 0) d5 = bus.res_din;
                else if (bus.res_din != d5) hold_chg++;
                hold5++;
            end
            if (bus.res_we && bus.res_ready) begin
                if (first_wr < 0) first_wr = c;
                if (n_wr < 64) begin
                    wa[n_wr] = bus.res_addr;
                    wd[n_wr] = bus.res_din;
                end
                n_wr++;
            end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("idle_busy_after_done", bus.busy, 0);
        check("idle_we_after_done", bus.res_we, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        bus.base_addr = '0;
        clear_lanes();
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_we", bus.res_we, 0);
        check("rst_addr", bus.res_addr, 0);
        check("rst_din", bus.res_din, 0);
`ifdef JP_WCNT_EN
        check("rst_wr_count", wr_count, 0);
`endif
        set_lane(0, 160, 164, 156, 5'b01001);
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_beats_start_busy", bus.busy, 0);
        check("rst_beats_start_we", bus.res_we, 0);
        tick();

        // single odd lane
        run_job(10'd100, 0, 0);
        check("t1_nwr", n_wr, 1);
        check("t1_addr", wa[0], 100);
        check("t1_din", wd[0], 322);
        check("t1_first_cycle", first_wr, 1);
        check("t1_done_cycle", done_cyc, 17);
        check("t1_busy_cycles", busy_cyc, 16);

        // even lane, left edge, both edges
        set_lane(0, 160, 164, 156, 5'b01000);
        run_job(10'd100, 0, 0);
        check("t2_nwr", n_wr, 1);
        check("t2_even_din", wd[0], 85);
        set_lane(0, 160, 164, 156, 5'b01011);
        run_job(10'd100, 0, 0);
        check("t3_ledge_din", wd[0], 320);
        set_lane(0, 160, 164, 156, 5'b01111);
        run_job(10'd100, 0, 0);
        check("t4_both_din", wd[0], 328);

        // negative values, range extremes, reserved bit, disabled odd lane, right edge
        clear_lanes();
        set_lane(0, -100, -50, -60, 5'b01000);
        set_lane(1, -100, -50, -60, 5'b11001);
        set_lane(2, 255, 255, 255, 5'b01001);
        set_lane(3, 255, -256, 255, 5'b01000);
        set_lane(4, 1, 2, 3, 5'b00001);
        set_lane(5, 10, 20, 99, 5'b01101);
        run_job(10'd200, 0, 0);
        check("t5_nwr", n_wr, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_addr%0d", i), wa[i], exp_a[i]);
            check($sformatf("t5_din%0d", i), wd[i], exp_d[i]);
        end
        check("t5_done_cycle", done_cyc, 17);

        // all lanes, address wrap
        for (int i = 0; i < LANES; i++) set_lane(i, 160, 164, 156, (i % 2) ? 5'b01001 : 5'b01000);
        run_job(10'd1020, 0, 0);
        check("t6_nwr", n_wr, 16);
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("t6_addr%0d", i), wa[i], (1020 + i) % 1024);
            check($sformatf("t6_din%0d", i), wd[i], (i % 2) ? 322 : 85);
        end
        check("t6_busy_cycles", busy_cyc, 16);
        check("t6_done_cycle", done_cyc, 17);

        // back-pressure on lane 5
        run_job(10'd0, 6, 3);
        check("t7_nwr", n_wr, 16);
        check("t7_hold_cycles", hold5, 4);
        check("t7_hold_changes", hold_chg, 0);
        check("t7_lane5_addr", wa[5], 5);
        check("t7_lane5_din", wd[5], 322);
        check("t7_lane6_addr", wa[6], 6);
        check("t7_done_cycle", done_cyc, 20);
        check("t7_busy_cycles", busy_cyc, 19);

        // reset in the middle of a job
        bus.base_addr = 10'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        check("t8_lane8_addr", bus.res_addr, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t8_busy", bus.busy, 0);
        check("t8_we", bus.res_we, 0);
        check("t8_done", bus.done, 0);
        check("t8_addr", bus.res_addr, 0);
        check("t8_din", bus.res_din, 0);
`ifdef JP_WCNT_EN
        check("t8_wr_count", wr_count, 0);
`endif
        n_done = 0;
        n_w = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.done) n_done++;
            if (bus.res_we) n_w++;
        end
        check("t8_no_done", n_done, 0);
        check("t8_no_writes", n_w, 0);

        // clean job after reset
        clear_lanes();
        set_lane(0, 160, 164, 156, 5'b01001);
        run_job(10'd100, 0, 0);
        check("t9_nwr", n_wr, 1);
        check("t9_din", wd[0], 322);
        check("t9_done_cycle", done_cyc, 17);

        // seven enabled lanes
        clear_lanes();
        for (int i = 0; i < 7; i++) set_lane(i, 160, 164, 156, 5'b01000);
        run_job(10'd500, 0, 0);
        check("t10_nwr", n_wr, 7);
        check("t10_last_addr", wa[6], 506);
        check("t10_last_din", wd[6], 85);
`ifdef JP_WCNT_EN
        check("t10_wr_count", wr_count, 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
